// File: rtl/alu_pkg.sv
// Shared ALU definitions: command codes, collector states and the operand-need decode.
package alu_pkg;

   localparam int OP_W        = 8;
   localparam int CMD_W       = 4;
   localparam int TIMEOUT_CYC = 16;

   localparam logic [CMD_W-1:0] ARI_ADD       = 4'd0;
   localparam logic [CMD_W-1:0] ARI_SUB       = 4'd1;
   localparam logic [CMD_W-1:0] ARI_ADD_CIN   = 4'd2;
   localparam logic [CMD_W-1:0] ARI_SUB_CIN   = 4'd3;
   localparam logic [CMD_W-1:0] ARI_INC_A     = 4'd4;
   localparam logic [CMD_W-1:0] ARI_DEC_A     = 4'd5;
   localparam logic [CMD_W-1:0] ARI_INC_B     = 4'd6;
   localparam logic [CMD_W-1:0] ARI_DEC_B     = 4'd7;
   localparam logic [CMD_W-1:0] ARI_CMP       = 4'd8;
   localparam logic [CMD_W-1:0] ARI_MUL_INC   = 4'd9;
   localparam logic [CMD_W-1:0] ARI_MUL_SHIFT = 4'd10;

   localparam logic [CMD_W-1:0] LOG_AND     = 4'd0;
   localparam logic [CMD_W-1:0] LOG_NAND    = 4'd1;
   localparam logic [CMD_W-1:0] LOG_OR      = 4'd2;
   localparam logic [CMD_W-1:0] LOG_NOR     = 4'd3;
   localparam logic [CMD_W-1:0] LOG_XOR     = 4'd4;
   localparam logic [CMD_W-1:0] LOG_XNOR    = 4'd5;
   localparam logic [CMD_W-1:0] LOG_NOT_A   = 4'd6;
   localparam logic [CMD_W-1:0] LOG_NOT_B   = 4'd7;
   localparam logic [CMD_W-1:0] LOG_SHR1_A  = 4'd8;
   localparam logic [CMD_W-1:0] LOG_SHL1_A  = 4'd9;
   localparam logic [CMD_W-1:0] LOG_SHR1_B  = 4'd10;
   localparam logic [CMD_W-1:0] LOG_SHL1_B  = 4'd11;
   localparam logic [CMD_W-1:0] LOG_ROL_A_B = 4'd12;
   localparam logic [CMD_W-1:0] LOG_ROR_A_B = 4'd13;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT_A = 2'd1,
      ST_WAIT_B = 2'd2,
      ST_ISSUE  = 2'd3
   } coll_state_e;

   function automatic logic cmd_invalid(input logic mode, input logic [CMD_W-1:0] cmd);
      return mode ? (cmd > ARI_MUL_SHIFT) : (cmd > LOG_ROR_A_B);
   endfunction

   // Bit 0 = operand A required, bit 1 = operand B required.
   function automatic logic [1:0] need_ops(input logic mode, input logic [CMD_W-1:0] cmd);
      logic [1:0] need;
      need = 2'b11;
      if (mode) begin
         case (cmd)
            ARI_INC_A, ARI_DEC_A: need = 2'b01;
            ARI_INC_B, ARI_DEC_B: need = 2'b10;
            default:              need = 2'b11;
         endcase
      end else begin
         case (cmd)
            LOG_NOT_A, LOG_SHR1_A, LOG_SHL1_A: need = 2'b01;
            LOG_NOT_B, LOG_SHR1_B, LOG_SHL1_B: need = 2'b10;
            default:                           need = 2'b11;
         endcase
      end
      return need;
   endfunction

endpackage

// File: rtl/alu_operand_collector_if.sv
// Beat input and ALU issue bundle of the operand collector.
interface alu_operand_collector_if #(
   parameter int N = 8,
   parameter int M = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_sel;
   logic         in_mode;
   logic [M-1:0] in_cmd;
   logic [N-1:0] in_opa;
   logic [N-1:0] in_opb;
   logic         in_cin;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   out_inp_valid;
   logic         out_mode;
   logic [M-1:0] out_cmd;
   logic [N-1:0] out_opa;
   logic [N-1:0] out_opb;
   logic         out_cin;
   logic         timeout_err;

   modport master (
      output in_valid, in_sel, in_mode, in_cmd, in_opa, in_opb, in_cin, out_ready,
      input  in_ready, out_valid, out_inp_valid, out_mode, out_cmd, out_opa, out_opb,
             out_cin, timeout_err
   );

   modport slave (
      input  in_valid, in_sel, in_mode, in_cmd, in_opa, in_opb, in_cin, out_ready,
      output in_ready, out_valid, out_inp_valid, out_mode, out_cmd, out_opa, out_opb,
             out_cin, timeout_err
   );
endinterface

// File: rtl/alu_window_timer.sv
// Second-operand window timer: clear loads "one cycle elapsed", counts while enabled, saturates.
module alu_window_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);
   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= W'(1);
      end else if (enable_i && (count_q != W'(TIMEOUT))) begin
         count_q <= count_q + W'(1);
      end
   end

   // Last cycle of the window; the collector lets a completing beat win over this.
   assign expire_o = enable_i && (count_q >= W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_operand_collector.sv
// Merges split A/B beats into one ALU issue, with a second-operand timeout.
//   state     | meaning
//   ST_IDLE   | ready for a new op
//   ST_WAIT_A | holding B, waiting for A
//   ST_WAIT_B | holding A, waiting for B
//   ST_ISSUE  | issue presented, held until out_ready
module alu_operand_collector
   import alu_pkg::*;
#(
   parameter int N       = 8,
   parameter int M       = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   alu_operand_collector_if.slave  bus
);

   coll_state_e  state_q;
   logic         in_ready_q;
   logic         out_valid_q;
   logic [1:0]   out_inp_valid_q;
   logic         out_mode_q;
   logic [M-1:0] out_cmd_q;
   logic [N-1:0] out_opa_q;
   logic [N-1:0] out_opb_q;
   logic         out_cin_q;
   logic         err_q;

   logic       accept;
   logic [1:0] need;
   logic       split;
   logic       timer_clear;
   logic       timer_en;
   logic       expire;

   assign accept = bus.in_valid && in_ready_q;
   assign need   = need_ops(bus.in_mode, bus.in_cmd);
   // Only valid two-operand commands arriving with exactly one operand wait for a partner.
   assign split  = (need == 2'b11) && !cmd_invalid(bus.in_mode, bus.in_cmd) &&
                   ((bus.in_sel == 2'b01) || (bus.in_sel == 2'b10));

   assign timer_clear = accept && (state_q == ST_IDLE) && split;
   assign timer_en    = (state_q == ST_WAIT_A) || (state_q == ST_WAIT_B);

   alu_window_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (timer_clear),
      .enable_i (timer_en),
      .expire_o (expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         in_ready_q      <= 1'b0;
         out_valid_q     <= 1'b0;
         out_inp_valid_q <= 2'b00;
         out_mode_q      <= 1'b0;
         out_cmd_q       <= '0;
         out_opa_q       <= '0;
         out_opb_q       <= '0;
         out_cin_q       <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  out_mode_q <= bus.in_mode;
                  out_cmd_q  <= bus.in_cmd;
                  out_cin_q  <= bus.in_cin;
                  out_opa_q  <= bus.in_opa;
                  out_opb_q  <= bus.in_opb;
                  if (split) begin
                     state_q <= bus.in_sel[0] ? ST_WAIT_B : ST_WAIT_A;
                  end else begin
                     state_q         <= ST_ISSUE;
                     out_valid_q     <= 1'b1;
                     out_inp_valid_q <= bus.in_sel;
                     in_ready_q      <= 1'b0;
                  end
               end
            end
            ST_WAIT_A: begin
               if (accept && bus.in_sel[0]) begin
                  out_opa_q       <= bus.in_opa;
                  state_q         <= ST_ISSUE;
                  out_valid_q     <= 1'b1;
                  out_inp_valid_q <= 2'b11;
                  in_ready_q      <= 1'b0;
               end else begin
                  if (accept && bus.in_sel[1]) begin
                     out_opb_q <= bus.in_opb;
                  end
                  if (expire) begin
                     state_q <= ST_IDLE;
                     err_q   <= 1'b1;
                  end
               end
            end
            ST_WAIT_B: begin
               if (accept && bus.in_sel[1]) begin
                  out_opb_q       <= bus.in_opb;
                  state_q         <= ST_ISSUE;
                  out_valid_q     <= 1'b1;
                  out_inp_valid_q <= 2'b11;
                  in_ready_q      <= 1'b0;
               end else begin
                  if (accept && bus.in_sel[0]) begin
                     out_opa_q <= bus.in_opa;
                  end
                  if (expire) begin
                     state_q <= ST_IDLE;
                     err_q   <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (bus.out_ready) begin
                  state_q         <= ST_IDLE;
                  out_valid_q     <= 1'b0;
                  out_inp_valid_q <= 2'b00;
                  in_ready_q      <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_inp_valid = out_inp_valid_q;
   assign bus.out_mode      = out_mode_q;
   assign bus.out_cmd       = out_cmd_q;
   assign bus.out_opa       = out_opa_q;
   assign bus.out_opb       = out_opb_q;
   assign bus.out_cin       = out_cin_q;
   assign bus.timeout_err   = err_q;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Scoreboard bench: stimulus pushes expected issues/timeouts, a negedge monitor pops and compares.
module tb_alu_operand_collector;
   import alu_pkg::*;

   typedef struct {
      logic [1:0] iv;
      logic       mode;
      logic [3:0] cmd;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      int         cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_pass;
   exp_t exp_q[$];
   int   err_q[$];

   alu_operand_collector_if #(.N(8), .M(4)) bus ();

   alu_operand_collector #(.N(8), .M(4), .TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: compares each new issue against the scoreboard, checks holds and timeout pulses.
   initial begin
      exp_t e;
      logic prev_v;
      logic [27:0] cap;
      prev_v = 1'b0;
      cap = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_v = 1'b0;
         end else begin
            if (bus.out_valid && !prev_v) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_issue", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("issue_cycle", cyc, e.cyc);
                  chk("out_inp_valid", bus.out_inp_valid, e.iv);
                  chk("out_mode", bus.out_mode, e.mode);
                  chk("out_cmd", bus.out_cmd, e.cmd);
                  chk("out_opa", bus.out_opa, e.a);
                  chk("out_opb", bus.out_opb, e.b);
                  chk("out_cin", bus.out_cin, e.cin);
               end
               cap = {bus.out_inp_valid, bus.out_mode, bus.out_cmd, bus.out_opa,
                      bus.out_opb, bus.out_cin};
            end else if (bus.out_valid && prev_v) begin
               chk("issue_hold_stable", {bus.out_inp_valid, bus.out_mode, bus.out_cmd,
                   bus.out_opa, bus.out_opb, bus.out_cin}, cap);
            end
            prev_v = bus.out_valid;
            if (bus.timeout_err) begin
               if (err_q.size() == 0) chk("unexpected_timeout", 1, 0);
               else chk("timeout_cycle", cyc, err_q.pop_front());
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one beat for a single cycle once in_ready is seen; t is its accept cycle.
   task automatic beat(input logic [1:0] sel, input logic mode, input logic [3:0] cmd,
                       input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output int t);
      int n;
      n = 0;
      while (!bus.in_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("in_ready_for_beat", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_sel   = sel;
      bus.in_mode  = mode;
      bus.in_cmd   = cmd;
      bus.in_opa   = a;
      bus.in_opb   = b;
      bus.in_cin   = cin;
      t = cyc;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sel   = 2'b00;
   endtask

   function automatic exp_t mk(input logic [1:0] iv, input logic mode, input logic [3:0] cmd,
                               input logic [7:0] a, input logic [7:0] b, input logic cin,
                               input int c);
      exp_t e;
      e.iv = iv; e.mode = mode; e.cmd = cmd; e.a = a; e.b = b; e.cin = cin; e.cyc = c;
      return e;
   endfunction

   initial begin
      int t, t2;
      n_checks = 0;
      n_pass   = 0;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_sel = 2'b00; bus.in_mode = 1'b0; bus.in_cmd = 4'd0;
      bus.in_opa = 8'h00; bus.in_opb = 8'h00; bus.in_cin = 1'b0; bus.out_ready = 1'b1;

      #3;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_inp_valid", bus.out_inp_valid, 0);
      chk("rst_timeout_err", bus.timeout_err, 0);
      chk("rst_out_fields", {bus.out_mode, bus.out_cmd, bus.out_opa, bus.out_opb, bus.out_cin}, 0);
      @(posedge clk); #1;
      chk("rst_held_in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_reset", bus.in_ready, 1);

      // 1: ADD with both operands in one beat
      beat(2'b11, 1'b1, ARI_ADD, 8'h12, 8'h34, 1'b0, t);
      exp_q.push_back(mk(2'b11, 1'b1, ARI_ADD, 8'h12, 8'h34, 1'b0, t + 1));
      idle(1);
      chk("t1_out_valid_cleared", bus.out_valid, 0);
      chk("t1_inp_valid_cleared", bus.out_inp_valid, 0);
      chk("t1_in_ready_back", bus.in_ready, 1);

      // 2: split SUB, B five cycles after A; second beat's cmd/mode/cin ignored
      beat(2'b01, 1'b1, ARI_SUB, 8'h50, 8'h00, 1'b1, t);
      idle(4);
      beat(2'b10, 1'b0, 4'd0, 8'h00, 8'h10, 1'b0, t2);
      chk("t2_b_offset", t2 - t, 5);
      exp_q.push_back(mk(2'b11, 1'b1, ARI_SUB, 8'h50, 8'h10, 1'b1, t2 + 1));
      idle(2);

      // 3: AND with A only; an A-only overwrite must not restart the window
      beat(2'b01, 1'b0, LOG_AND, 8'hAA, 8'h00, 1'b0, t);
      err_q.push_back(t + 16);
      idle(7);
      beat(2'b01, 1'b0, LOG_AND, 8'hBB, 8'h00, 1'b0, t2);
      idle(7);
      idle(1);
      chk("t3_in_ready_after_timeout", bus.in_ready, 1);
      chk("t3_no_issue", bus.out_valid, 0);
      chk("t3_cycle", cyc, t + 17);

      // 4: MUL_INC, B on the last cycle of the window
      beat(2'b01, 1'b1, ARI_MUL_INC, 8'h07, 8'h00, 1'b0, t);
      idle(14);
      beat(2'b10, 1'b1, ARI_MUL_INC, 8'h00, 8'h03, 1'b0, t2);
      chk("t4_b_offset", t2 - t, 15);
      exp_q.push_back(mk(2'b11, 1'b1, ARI_MUL_INC, 8'h07, 8'h03, 1'b0, t2 + 1));
      idle(2);

      // 5: single-operand, invalid and no-operand beats pass straight through
      beat(2'b10, 1'b1, ARI_INC_B, 8'h00, 8'h0F, 1'b0, t);
      exp_q.push_back(mk(2'b10, 1'b1, ARI_INC_B, 8'h00, 8'h0F, 1'b0, t + 1));
      beat(2'b01, 1'b1, 4'd12, 8'h33, 8'h44, 1'b1, t);
      exp_q.push_back(mk(2'b01, 1'b1, 4'd12, 8'h33, 8'h44, 1'b1, t + 1));
      beat(2'b00, 1'b0, LOG_OR, 8'h01, 8'h02, 1'b0, t);
      exp_q.push_back(mk(2'b00, 1'b0, LOG_OR, 8'h01, 8'h02, 1'b0, t + 1));
      idle(2);

      // 6: split XOR stalled by out_ready=0, then reset pulsed while waiting for B
      bus.out_ready = 1'b0;
      beat(2'b01, 1'b0, LOG_XOR, 8'hF0, 8'h00, 1'b0, t);
      beat(2'b10, 1'b0, LOG_XOR, 8'h00, 8'h0F, 1'b0, t2);
      exp_q.push_back(mk(2'b11, 1'b0, LOG_XOR, 8'hF0, 8'h0F, 1'b0, t2 + 1));
      for (int i = 0; i < 4; i++) begin
         chk("t6_in_ready_stalled", bus.in_ready, 0);
         chk("t6_out_valid_stalled", bus.out_valid, 1);
         idle(1);
      end
      bus.out_ready = 1'b1;
      idle(1);
      chk("t6_released", bus.out_valid, 0);

      beat(2'b01, 1'b0, LOG_XOR, 8'h5A, 8'h00, 1'b0, t);
      idle(1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_out_valid", bus.out_valid, 0);
      chk("t6_rst_in_ready", bus.in_ready, 0);
      chk("t6_rst_err", bus.timeout_err, 0);
      chk("t6_rst_fields", {bus.out_inp_valid, bus.out_mode, bus.out_cmd, bus.out_opa,
          bus.out_opb, bus.out_cin}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("t6_in_ready_after_reset", bus.in_ready, 1);
      idle(20);
      chk("t6_no_issue_after_reset", bus.out_valid, 0);

      chk("issues_left_unseen", exp_q.size(), 0);
      chk("timeouts_left_unseen", err_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
